agendador_rega: RTL

AGENDADOR_REGA -- requirements
Module: agendador_rega

---
 rtl/agendador_rega.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/agendador_rega.sv
`default_nettype none
// ============================================================================
// Module   : agendador_rega
// Purpose  : Irrigation/fertilization scheduler FSM with reservoir refill and
//            fault handling; all timing is counted in Tick pulses.
// Revision : 1.0 - initial release
// ============================================================================
module agendador_rega #(
    parameter int T_ASP  = 15,
    parameter int T_GOT  = 30,
    parameter int T_MIST = 8,
    parameter int T_LIMP = 4,
    parameter int T_ENCH = 40
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick,
    input  logic       ReqRega,
    input  logic       Tipo,
    input  logic       ReqAdub,
    input  logic       NvBaixo,
    input  logic       Ack,
    output logic       ValvA,
    output logic       ValvG,
    output logic       Ve,
    output logic       Mist,
    output logic       Limp,
    output logic       Ocupado,
    output logic [2:0] Fase,
    output logic [5:0] Tempo
);

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        ENCHE  = 3'd1,
        REGA   = 3'd2,
        MISTUR = 3'd3,
        LIMPA  = 3'd4,
        ERRO   = 3'd5
    } estadoT;

    localparam logic [5:0] c_tAsp  = 6'(T_ASP);
    localparam logic [5:0] c_tGot  = 6'(T_GOT);
    localparam logic [5:0] c_tMist = 6'(T_MIST);
    localparam logic [5:0] c_tLimp = 6'(T_LIMP);
    localparam logic [5:0] c_tEnch = 6'(T_ENCH);

    estadoT     r_state;
    logic [5:0] r_tempo;
    logic [5:0] r_saved;
    logic       r_resume;
    logic       r_tipoL;
    logic       r_pendRega;
    logic       r_pendAdub;

    estadoT     w_nState;
    logic [5:0] w_nTempo;
    logic [5:0] w_nSaved;
    logic       w_nResume;
    logic       w_nTipo;
    logic       w_clrRega;
    logic       w_clrAdub;
    logic       w_nPendRega;
    logic       w_nPendAdub;
    logic       w_expira;

    // Expiry is "at or below one" so a zero count can never be decremented.
    assign w_expira = Tick && (r_tempo <= 6'd1);

    always_comb begin
        w_nState  = r_state;
        w_nTempo  = r_tempo;
        w_nSaved  = r_saved;
        w_nResume = r_resume;
        w_nTipo   = r_tipoL;
        w_clrRega = 1'b0;
        w_clrAdub = 1'b0;
        case (r_state)
            OCIOSO: begin
                if (NvBaixo && (r_pendRega || r_pendAdub)) begin
                    w_nState = ENCHE;
                    w_nTempo = c_tEnch;
                end else if (r_pendAdub) begin
                    w_nState  = MISTUR;
                    w_nTempo  = c_tMist;
                    w_clrAdub = 1'b1;
                end else if (r_pendRega) begin
                    w_nState  = REGA;
                    w_nTipo   = Tipo;
                    w_nTempo  = Tipo ? c_tAsp : c_tGot;
                    w_clrRega = 1'b1;
                end
            end
            REGA: begin
                if (NvBaixo) begin
                    w_nState  = ENCHE;
                    w_nSaved  = r_tempo;
                    w_nResume = 1'b1;
                    w_nTempo  = c_tEnch;
                end else if (w_expira) begin
                    w_nState = OCIOSO;
                    w_nTempo = 6'd0;
                end else if (Tick) begin
                    w_nTempo = r_tempo - 6'd1;
                end
            end
            ENCHE: begin
                if (!NvBaixo) begin
                    if (r_resume) begin
                        w_nState  = REGA;
                        w_nTempo  = r_saved;
                        w_nResume = 1'b0;
                    end else begin
                        w_nState = OCIOSO;
                        w_nTempo = 6'd0;
                    end
                end else if (w_expira) begin
                    w_nState  = ERRO;
                    w_nTempo  = 6'd0;
                    w_nResume = 1'b0;
                end else if (Tick) begin
                    w_nTempo = r_tempo - 6'd1;
                end
            end
            MISTUR: begin
                if (w_expira) begin
                    w_nState = LIMPA;
                    w_nTempo = c_tLimp;
                end else if (Tick) begin
                    w_nTempo = r_tempo - 6'd1;
                end
            end
            LIMPA: begin
                if (w_expira) begin
                    w_nState = OCIOSO;
                    w_nTempo = 6'd0;
                end else if (Tick) begin
                    w_nTempo = r_tempo - 6'd1;
                end
            end
            ERRO: begin
                w_nTempo = 6'd0;
                if (Ack) begin
                    w_nState  = OCIOSO;
                    w_clrRega = 1'b1;
                    w_clrAdub = 1'b1;
                end
            end
            default: begin
                w_nState = OCIOSO;
                w_nTempo = 6'd0;
            end
        endcase
    end

    // Acknowledging a fault flushes requests outright; elsewhere a live request re-arms its flag.
    always_comb begin
        if (r_state == ERRO && Ack) begin
            w_nPendRega = 1'b0;
            w_nPendAdub = 1'b0;
        end else begin
            w_nPendRega = (r_pendRega && !w_clrRega) || ReqRega;
            w_nPendAdub = (r_pendAdub && !w_clrAdub) || ReqAdub;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= OCIOSO;
            r_tempo    <= 6'd0;
            r_saved    <= 6'd0;
            r_resume   <= 1'b0;
            r_tipoL    <= 1'b0;
            r_pendRega <= 1'b0;
            r_pendAdub <= 1'b0;
            ValvA      <= 1'b0;
            ValvG      <= 1'b0;
            Ve         <= 1'b0;
            Mist       <= 1'b0;
            Limp       <= 1'b0;
            Ocupado    <= 1'b0;
            Fase       <= 3'd0;
            Tempo      <= 6'd0;
        end else begin
            r_state    <= w_nState;
            r_tempo    <= w_nTempo;
            r_saved    <= w_nSaved;
            r_resume   <= w_nResume;
            r_tipoL    <= w_nTipo;
            r_pendRega <= w_nPendRega;
            r_pendAdub <= w_nPendAdub;
            ValvA      <= (w_nState == REGA) && w_nTipo;
            ValvG      <= (w_nState == REGA) && !w_nTipo;
            Ve         <= (w_nState == ENCHE);
            Mist       <= (w_nState == MISTUR);
            Limp       <= (w_nState == LIMPA);
            Ocupado    <= (w_nState != OCIOSO);
            Fase       <= w_nState;
            Tempo      <= w_nTempo;
        end
    end

endmodule
`default_nettype wire
